// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic request front end.
// The liveness bounds reuse these defaults so the service limit is defined once.
package traffic_pkg;

    typedef enum logic [0:0] {CH_PED, CH_TURN} channel_t;

    localparam int NUM_CH              = 2;
    localparam int DEF_OVERDUE_LIMIT   = 50;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/request_channel.sv
// One request channel: synchronizer, debouncer, sticky request latch,
// saturating wait-age counter and overdue flag.
module request_channel
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AGE_WIDTH       = 6,
    parameter int OVERDUE_LIMIT   = DEF_OVERDUE_LIMIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 raw,
    input  logic                 green,
    output logic                 request,
    output logic [AGE_WIDTH-1:0] age,
    output logic                 overdue
);

    localparam logic [7:0]           DB_LAST_C   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX_C   = {AGE_WIDTH{1'b1}};
    localparam logic [AGE_WIDTH-1:0] AGE_ZERO_C  = {AGE_WIDTH{1'b0}};
    localparam logic [AGE_WIDTH-1:0] AGE_LIMIT_C = AGE_WIDTH'(OVERDUE_LIMIT);

    function automatic logic [AGE_WIDTH-1:0] sat_inc(input logic [AGE_WIDTH-1:0] value);
        if (value == AGE_MAX_C) begin
            return value;
        end else begin
            return value + AGE_WIDTH'(1);
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   stable_r;
    logic                   stable_next_s;
    logic [7:0]             db_cnt_r;
    logic [7:0]             db_cnt_next_s;
    logic                   rise_s;
    logic                   req_r;
    logic                   req_next_s;
    logic [AGE_WIDTH-1:0]   age_r;
    logic [AGE_WIDTH-1:0]   age_next_s;
    logic                   overdue_r;
    logic                   overdue_next_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous raw input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_next_s = stable_r;
        db_cnt_next_s = 8'd0;
        rise_s        = 1'b0;
        if (sync_s != stable_r) begin
            if (db_cnt_r == DB_LAST_C) begin
                stable_next_s = sync_s;
                db_cnt_next_s = 8'd0;
                rise_s        = sync_s;
            end else begin
                db_cnt_next_s = db_cnt_r + 8'd1;
            end
        end else begin
            db_cnt_next_s = 8'd0;
        end
    end

    // Request latch with grant dominance, age counter and overdue flag.
    always_comb begin
        req_next_s = (req_r | rise_s) & ~green;
        // Age restarts at zero on the rising edge of the request itself.
        if (req_next_s && req_r) begin
            age_next_s = sat_inc(age_r);
        end else begin
            age_next_s = AGE_ZERO_C;
        end
        overdue_next_s = req_next_s & (age_next_s >= AGE_LIMIT_C);
    end

    // State registers for debouncer, request, age and overdue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_r  <= 1'b0;
            db_cnt_r  <= 8'd0;
            req_r     <= 1'b0;
            age_r     <= AGE_ZERO_C;
            overdue_r <= 1'b0;
        end else begin
            stable_r  <= stable_next_s;
            db_cnt_r  <= db_cnt_next_s;
            req_r     <= req_next_s;
            age_r     <= age_next_s;
            overdue_r <= overdue_next_s;
        end
    end

    assign request = req_r;
    assign age     = age_r;
    assign overdue = overdue_r;

endmodule

// File: rtl/request_conditioner.sv
// Conditions the raw pedestrian button and turn sensor into latched, aged
// service requests for the intersection controller.
module request_conditioner
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AGE_WIDTH       = 6,
    parameter int OVERDUE_LIMIT   = DEF_OVERDUE_LIMIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ped_button_raw,
    input  logic                 turn_sensor_raw,
    input  logic                 pedestrian_green,
    input  logic                 turn_green,
    output logic                 pedestrian_button,
    output logic                 turn_sensor,
    output logic [AGE_WIDTH-1:0] ped_age,
    output logic [AGE_WIDTH-1:0] turn_age,
    output logic                 ped_overdue,
    output logic                 turn_overdue
);

    request_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .AGE_WIDTH       (AGE_WIDTH),
        .OVERDUE_LIMIT   (OVERDUE_LIMIT)
    ) u_ped (
        .clock   (clock),
        .reset   (reset),
        .raw     (ped_button_raw),
        .green   (pedestrian_green),
        .request (pedestrian_button),
        .age     (ped_age),
        .overdue (ped_overdue)
    );

    request_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .AGE_WIDTH       (AGE_WIDTH),
        .OVERDUE_LIMIT   (OVERDUE_LIMIT)
    ) u_turn (
        .clock   (clock),
        .reset   (reset),
        .raw     (turn_sensor_raw),
        .green   (turn_green),
        .request (turn_sensor),
        .age     (turn_age),
        .overdue (turn_overdue)
    );

endmodule

// File: tb/tb_request_conditioner.sv
// Self-checking bench for request_conditioner: directed scenarios plus a
// randomized run against a sample-history reference model.
module tb_request_conditioner;
    import traffic_pkg::*;

    localparam int SYNC = 2;
    localparam int DB   = DEF_DEBOUNCE_CYCLES;
    localparam int AW   = 6;
    localparam int LIM  = DEF_OVERDUE_LIMIT;
    localparam int AMAX = 63;
    localparam int HL   = SYNC + DB;

    logic          clock;
    logic          reset;
    logic          ped_button_raw;
    logic          turn_sensor_raw;
    logic          pedestrian_green;
    logic          turn_green;
    logic          pedestrian_button;
    logic          turn_sensor;
    logic [AW-1:0] ped_age;
    logic [AW-1:0] turn_age;
    logic          ped_overdue;
    logic          turn_overdue;

    int checks = 0;
    int passed = 0;

    // Reference model: raw samples per edge, debounced level, request, age, overdue.
    bit m_hist [2][HL];
    bit m_stable [2];
    bit m_req [2];
    bit m_over [2];
    int m_age [2];

    request_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .AGE_WIDTH       (AW),
        .OVERDUE_LIMIT   (LIM)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ped_button_raw    (ped_button_raw),
        .turn_sensor_raw   (turn_sensor_raw),
        .pedestrian_green  (pedestrian_green),
        .turn_green        (turn_green),
        .pedestrian_button (pedestrian_button),
        .turn_sensor       (turn_sensor),
        .ped_age           (ped_age),
        .turn_age          (turn_age),
        .ped_overdue       (ped_overdue),
        .turn_overdue      (turn_overdue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < HL; i++) m_hist[ch][i] = 1'b0;
            m_stable[ch] = 1'b0;
            m_req[ch]    = 1'b0;
            m_over[ch]   = 1'b0;
            m_age[ch]    = 0;
        end
    endtask

    // The level seen by the debouncer at edge n is the raw sample from edge n-SYNC;
    // it flips once the last DB such samples all disagree with the current level.
    task automatic model_edge(input int ch, input bit raw, input bit green);
        bit flip;
        bit rise;
        bit nreq;
        int nage;
        for (int i = 0; i < HL - 1; i++) m_hist[ch][i] = m_hist[ch][i+1];
        m_hist[ch][HL-1] = raw;
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (m_hist[ch][i] == m_stable[ch]) flip = 1'b0;
        rise = flip && !m_stable[ch];
        if (flip) m_stable[ch] = !m_stable[ch];
        nreq = (m_req[ch] || rise) && !green;
        nage = (nreq && m_req[ch]) ? ((m_age[ch] + 1 > AMAX) ? AMAX : m_age[ch] + 1) : 0;
        m_over[ch] = nreq && (nage >= LIM);
        m_req[ch]  = nreq;
        m_age[ch]  = nage;
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) begin
            model_clear();
        end else begin
            model_edge(0, ped_button_raw, pedestrian_green);
            model_edge(1, turn_sensor_raw, turn_green);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ped_button_raw = 1'b0; turn_sensor_raw = 1'b0;
        pedestrian_green = 1'b0; turn_green = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age} !== '0)
            $display("FAIL reset_async outputs=%b required all zero",
                     {pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age});
        else passed++;
        @(negedge clock);
        idle(3);
        reset = 1'b1;
        step();
        checks++;
        if ({pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age} !== '0)
            $display("FAIL reset_first_edge outputs=%b required all zero",
                     {pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age});
        else passed++;
    endtask

    task automatic test_clean_press();
        ped_button_raw = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 5) begin
                checks++;
                if (pedestrian_button !== 1'b0) $display("FAIL press_edge5 got %b required 0", pedestrian_button);
                else passed++;
            end
            if (e == 6) begin
                checks++;
                if (pedestrian_button !== 1'b1) $display("FAIL press_edge6 got %b required 1", pedestrian_button);
                else passed++;
            end
            if (e == 9) begin
                checks++;
                if (ped_age !== 6'd3) $display("FAIL press_age_edge9 got %0d required 3", ped_age);
                else passed++;
                pedestrian_green = 1'b1;
            end
            if (e == 10) begin
                checks++;
                if (pedestrian_button !== 1'b0 || ped_age !== 6'd0)
                    $display("FAIL grant_clear got req=%b age=%0d required req=0 age=0", pedestrian_button, ped_age);
                else passed++;
                pedestrian_green = 1'b0;
            end
        end
        ped_button_raw = 1'b0;
        idle(10);
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int c = 0; c < 30; c++) begin
            turn_sensor_raw = (c < 20) ? c[0] : 1'b0;
            step();
            checks++;
            if (turn_sensor !== 1'b0 || turn_age !== 6'd0) begin
                bad++;
                $display("FAIL bounce cycle %0d got req=%b age=%0d required req=0 age=0", c, turn_sensor, turn_age);
            end else passed++;
        end
    endtask

    task automatic test_overdue();
        ped_button_raw = 1'b1;
        idle(6);
        checks++;
        if (pedestrian_button !== 1'b1) $display("FAIL overdue_req_rise got %b required 1", pedestrian_button);
        else passed++;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == LIM - 1) begin
                checks++;
                if (ped_overdue !== 1'b0 || ped_age !== 6'(LIM - 1))
                    $display("FAIL overdue_before got ov=%b age=%0d required ov=0 age=%0d", ped_overdue, ped_age, LIM - 1);
                else passed++;
            end
            if (k == LIM) begin
                checks++;
                if (ped_overdue !== 1'b1 || ped_age !== 6'(LIM))
                    $display("FAIL overdue_at got ov=%b age=%0d required ov=1 age=%0d", ped_overdue, ped_age, LIM);
                else passed++;
            end
            if (k == AMAX || k == 70) begin
                checks++;
                if (ped_age !== 6'(AMAX) || ped_overdue !== 1'b1)
                    $display("FAIL age_saturate k=%0d got age=%0d ov=%b required age=%0d ov=1", k, ped_age, ped_overdue, AMAX);
                else passed++;
            end
        end
        ped_button_raw = 1'b0;
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        idle(8);
    endtask

    task automatic test_simultaneous();
        ped_button_raw = 1'b1;
        turn_sensor_raw = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) begin
                checks++;
                if (pedestrian_button !== 1'b0 || turn_sensor !== 1'b0)
                    $display("FAIL simul_edge5 got ped=%b turn=%b required 0 0", pedestrian_button, turn_sensor);
                else passed++;
            end
        end
        checks++;
        if (pedestrian_button !== 1'b1 || turn_sensor !== 1'b1)
            $display("FAIL simul_edge6 got ped=%b turn=%b required 1 1", pedestrian_button, turn_sensor);
        else passed++;
        turn_green = 1'b1;
        step();
        turn_green = 1'b0;
        checks++;
        if (pedestrian_button !== 1'b1 || turn_sensor !== 1'b0 || ped_age !== 6'd1)
            $display("FAIL simul_turn_grant got ped=%b turn=%b ped_age=%0d required 1 0 1",
                     pedestrian_button, turn_sensor, ped_age);
        else passed++;
        step();
        checks++;
        if (pedestrian_button !== 1'b1 || turn_sensor !== 1'b0)
            $display("FAIL simul_after_grant got ped=%b turn=%b required 1 0", pedestrian_button, turn_sensor);
        else passed++;
        ped_button_raw = 1'b0;
        turn_sensor_raw = 1'b0;
        pedestrian_green = 1'b1;
        step();
        pedestrian_green = 1'b0;
        idle(8);
    endtask

    task automatic test_grant_dominance();
        turn_sensor_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 4) turn_green = 1'b1;
            if (e == 8) turn_green = 1'b0;
            checks++;
            if (turn_sensor !== 1'b0) $display("FAIL dominance_hold edge %0d got %b required 0", e, turn_sensor);
            else passed++;
        end
        turn_sensor_raw = 1'b0;
        idle(8);
        checks++;
        if (turn_sensor !== 1'b0) $display("FAIL dominance_release got %b required 0", turn_sensor);
        else passed++;
        turn_sensor_raw = 1'b1;
        idle(6);
        checks++;
        if (turn_sensor !== 1'b1) $display("FAIL dominance_repress got %b required 1", turn_sensor);
        else passed++;
        turn_sensor_raw = 1'b0;
        turn_green = 1'b1;
        step();
        turn_green = 1'b0;
        idle(8);
    endtask

    task automatic test_reset_mid();
        ped_button_raw = 1'b1;
        idle(6 + 20);
        checks++;
        if (pedestrian_button !== 1'b1 || ped_age !== 6'd20)
            $display("FAIL reset_mid_setup got req=%b age=%0d required req=1 age=20", pedestrian_button, ped_age);
        else passed++;
        #2;
        reset = 1'b0;
        ped_button_raw = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age} !== '0)
            $display("FAIL reset_mid_async outputs=%b required all zero",
                     {pedestrian_button, turn_sensor, ped_overdue, turn_overdue, ped_age, turn_age});
        else passed++;
        @(negedge clock);
        step();
        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (pedestrian_button !== 1'b0 || ped_age !== 6'd0)
                $display("FAIL reset_mid_after edge %0d got req=%b age=%0d required 0 0", e, pedestrian_button, ped_age);
            else passed++;
        end
    endtask

    task automatic test_random();
        int hold [2];
        bit lvl [2];
        hold[0] = 0; hold[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 8);
                end
                hold[ch]--;
            end
            ped_button_raw   = lvl[0];
            turn_sensor_raw  = lvl[1];
            pedestrian_green = ($urandom_range(0, 39) == 0);
            turn_green       = ($urandom_range(0, 39) == 0);
            step();
            checks++;
            if (pedestrian_button !== m_req[0] || ped_age !== AW'(m_age[0]) || ped_overdue !== m_over[0])
                $display("FAIL rand_ped cycle %0d got req=%b age=%0d ov=%b required req=%b age=%0d ov=%b",
                         c, pedestrian_button, ped_age, ped_overdue, m_req[0], m_age[0], m_over[0]);
            else passed++;
            checks++;
            if (turn_sensor !== m_req[1] || turn_age !== AW'(m_age[1]) || turn_overdue !== m_over[1])
                $display("FAIL rand_turn cycle %0d got req=%b age=%0d ov=%b required req=%b age=%0d ov=%b",
                         c, turn_sensor, turn_age, turn_overdue, m_req[1], m_age[1], m_over[1]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_overdue();
        test_simultaneous();
        test_grant_dominance();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/request_conditioner.md
# request_conditioner

Front-end stage directly upstream of `intersection`: conditions the raw asynchronous pedestrian push-button and turn-lane presence sensor into clean, latched service requests. Each raw input is synchronized, debounced, and turned into a sticky request that stays asserted until `intersection` grants the matching green. Per-channel wait-age counters flag requests that have waited past the service bound.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 4: consecutive samples needed to accept a level change; legal range 1..255.
- `AGE_WIDTH`, default 6: width of each wait-age counter.
- `OVERDUE_LIMIT`, default 50: age at which `*_overdue` asserts; must be < 2**AGE_WIDTH.

- `clock`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clock` (synchronizer provided externally).
- `ped_button_raw`  in  1  raw pedestrian button, asynchronous, may bounce.
- `turn_sensor_raw`  in  1  raw turn-lane presence sensor, asynchronous, may bounce.
- `pedestrian_green`  in  1  grant from `intersection`; clears the pedestrian request.
- `turn_green`  in  1  grant from `intersection`; clears the turn request.
- `pedestrian_button`  out  1  latched pedestrian request to `intersection`.
- `turn_sensor`  out  1  latched turn request to `intersection`.
- `ped_age`, `turn_age`  out  AGE_WIDTH  cycles current request has been pending, saturating.
- `ped_overdue`, `turn_overdue`  out  1  age >= OVERDUE_LIMIT.

## Operation
- Two identical, independent channels (pedestrian, turn). Per channel:
- Synchronizer: SYNC_STAGES flop chain on the raw input; the output of the last flop is `sync`.
- Debouncer: registered `stable` level plus counter `db_cnt`. While `sync != stable`, `db_cnt` increments each cycle; any cycle with `sync == stable` clears `db_cnt` to 0. `stable` takes the value of `sync` at the edge where `sync` has differed for DEBOUNCE_CYCLES consecutive sampled edges; `db_cnt` clears on that edge.
- `rise` = the edge at which `stable` goes 0->1. Falling `stable` has no effect on the request.
- Request latch: `req_next = (req | rise) & ~green`. The grant dominates: a rise during an asserted grant is discarded, because the user is already being served. A held-down button does not re-request after the grant drops; a new request needs a release and a new press.
- Age: while `req`=1, `age` increments by 1 per cycle, saturating at 2**AGE_WIDTH-1. The age is 0 when `req`=0. The age clears on the same edge that `req` clears.
- Overdue: registered, computed from the next-state age: `overdue_next = req_next & (age_next >= OVERDUE_LIMIT)`.
- Reset (asynchronous, any time, including mid-debounce or mid-request): all sync flops, `stable`, `db_cnt`, `req`, `age` and `overdue` go to 0. In-flight presses are lost.
- The channels share no state. Simultaneous events on both channels are handled independently in the same cycle.

## Timing
- All outputs are registered and are 0 during reset and on the first edge after reset.
- Press latency: the raw input is first sampled high at edge 1 and held stable. `sync`=1 after edge SYNC_STAGES. The request asserts after edge SYNC_STAGES + DEBOUNCE_CYCLES (6 with defaults).
- Glitch rejection: a raw pulse that yields fewer than DEBOUNCE_CYCLES consecutive `sync`=1 samples never sets the request.
- Grant latency: the grant is sampled high at edge n; the request is 0 after edge n, with no delay.
- Overdue asserts after the edge where `age` reaches OVERDUE_LIMIT, which is OVERDUE_LIMIT edges after `req` rose.
- The grant inputs come from `intersection` on the same clock and need no synchronization.

## Structure
- Package `traffic_pkg` holds:
  - `typedef enum logic [0:0] {CH_PED, CH_TURN} channel_t`;
  - `localparam int NUM_CH = 2`;
  - the default values of `OVERDUE_LIMIT` and `DEBOUNCE_CYCLES`, shared with the liveness properties so the 50-cycle bound is defined in one place.
- Sub-module `request_channel`: synchronizer, debouncer, request latch, age counter and overdue flag for one channel. `request_conditioner` instantiates it twice, once per channel, and wires the ports.

## Test plan
- Clean press: hold `ped_button_raw`=1 from edge 1. Required: `pedestrian_button`=1 after edge 6. Drive `pedestrian_green`=1 at edge 10. Required: `pedestrian_button`=0 and `ped_age`=0 after edge 10.
- Bounce: toggle `turn_sensor_raw` every cycle for 20 cycles, then hold it 0. Required: `turn_sensor` stays 0 and `turn_age` stays 0 throughout.
- Overdue: press the pedestrian button and never grant. Required: `ped_overdue`=1 exactly 50 edges after `pedestrian_button` rose, and `ped_age` saturates at 63 and holds there.
- Simultaneous events: press both buttons on the same edge. Required: both requests rise after the same edge. Grant only the turn channel. Required: only `turn_sensor` clears and the pedestrian request persists.
- Grant dominance: the debounced rise coincides with `turn_green`=1. Required: `turn_sensor` stays 0. Holding the button through the end of the grant produces no new request until a release and a re-press.
- Reset mid-operation: pull `reset` low asynchronously between clock edges while a request is pending and age=20. Required: all outputs are 0 immediately. After reset is released, no request appears unless a new press occurs.
